ad7606_emulator: RTL and testbench



---
 rtl/ad7606_emu_pkg.sv | 23 ++
 rtl/ad7606_emu_pattern.sv | 46 ++++
 rtl/ad7606_emulator.sv | 199 +++++++++++++++++++
 tb/tb_ad7606_emulator.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ad7606_emu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ad7606_emu_pkg
//  Purpose  : Shared constants and device state encoding for the AD7606
//             parallel-interface emulator.
//  Revision : 1.0 - initial release
// ============================================================================
package ad7606_emu_pkg;

    localparam int AD_DATA_W  = 16;  // width of one channel word
    localparam int AD_CHN_W   = 3;   // channel tag / read pointer width
    localparam int CONV_CNT_W = 13;  // conversion counter carried in each sample

    // Device operating states
    typedef enum logic [1:0] {
        DEV_RESET = 2'd0,
        IDLE      = 2'd1,
        CONVERT   = 2'd2,
        READY     = 2'd3
    } dev_state_e;

endpackage
`default_nettype wire

// File: rtl/ad7606_emu_pattern.sv
`default_nettype none
// ============================================================================
//  Module   : ad7606_emu_pattern
//  Purpose  : Holds the conversion counter and, on a load strobe, snapshots a
//             channel-tagged ramp word {channel, conv_cnt} for every channel.
//  Revision : 1.0 - initial release
// ============================================================================
module ad7606_emu_pattern
    import ad7606_emu_pkg::*;
#(
    parameter int P_CHANNELS = 8
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_load,
    output logic [P_CHANNELS-1:0][AD_DATA_W-1:0]  o_samples
);

    logic [CONV_CNT_W-1:0]                 conv_cnt_q;
    logic [CONV_CNT_W-1:0]                 conv_cnt_d;
    logic [P_CHANNELS-1:0][AD_DATA_W-1:0]  samples_q;
    logic [P_CHANNELS-1:0][AD_DATA_W-1:0]  samples_d;

    assign conv_cnt_d = conv_cnt_q + 1'b1;

    // Each channel word carries its own index in the top bits so a misrouted
    // word is obvious on the receiving side.
    for (genvar n = 0; n < P_CHANNELS; n++) begin : g_ch
        assign samples_d[n] = {AD_CHN_W'(n), conv_cnt_q};
    end

    // Snapshot all channels and advance the counter together on a load
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            conv_cnt_q <= '0;
            samples_q  <= '0;
        end else if (i_load) begin
            conv_cnt_q <= conv_cnt_d;
            samples_q  <= samples_d;
        end
    end

    assign o_samples = samples_q;

endmodule
`default_nettype wire

// File: rtl/ad7606_emulator.sv
`default_nettype none
// ============================================================================
//  Module   : ad7606_emulator
//  Purpose  : Device-side model of the AD7606 8-channel ADC in parallel mode.
//             Answers reset/convst/cs/rd with busy, firstdata and ramp data.
//  Options  : AD7606_EMU_OSC_EN - busy time scales with i_ad_osc
//             (P_CONV_CYCLES << osc, osc=7 treated as 0).
//  Revision : 1.0 - initial release
// ============================================================================
module ad7606_emulator
    import ad7606_emu_pkg::*;
#(
    parameter int P_CONV_CYCLES = 200,
    parameter int P_RESET_MIN   = 3,
    parameter int P_CHANNELS    = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_ad_range,
    input  logic [2:0]            i_ad_osc,
    input  logic                  i_ad_reset,
    input  logic                  i_ad_convstA,
    input  logic                  i_ad_convstB,
    input  logic                  i_ad_cs,
    input  logic                  i_ad_rd,
    output logic                  o_ad_busy,
    output logic                  o_ad_firstdata,
    output logic [AD_DATA_W-1:0]  o_ad_data,
    output logic                  o_overrun
);

`ifdef AD7606_EMU_OSC_EN
    localparam int BUSY_W = 22;
`else
    localparam int BUSY_W = 16;
`endif
    localparam int RST_CNT_W = 16;
    localparam int RD_CNT_W  = AD_CHN_W + 1;

    localparam logic [RST_CNT_W-1:0] c_rst_min   = RST_CNT_W'(P_RESET_MIN);
    localparam logic [AD_CHN_W-1:0]  c_last_chn  = AD_CHN_W'(P_CHANNELS - 1);
    localparam logic [RD_CNT_W-1:0]  c_all_reads = RD_CNT_W'(P_CHANNELS);

    dev_state_e               state_q, state_d;
    logic [BUSY_W-1:0]        busy_cnt_q, busy_cnt_d;
    logic [RST_CNT_W-1:0]     rst_cnt_q, rst_cnt_d;
    logic [AD_CHN_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [RD_CNT_W-1:0]      reads_q, reads_d;
    logic                     rd_q, conv_and_q;
    logic                     busy_q, busy_d;
    logic                     first_q, first_d;
    logic [AD_DATA_W-1:0]     data_q, data_d;
    logic                     overrun_q, overrun_d;

    logic                     w_load;
    logic                     w_trig;
    logic                     w_rd_fall;
    logic                     w_rd_rise;
    logic                     w_rst_hit;
    logic [BUSY_W-1:0]        w_busy_load;
    logic [P_CHANNELS-1:0][AD_DATA_W-1:0] w_samples;
    logic                     w_unused;

    // Range select has no effect on the synthetic data
    assign w_unused = ^{i_ad_range, i_ad_osc};

`ifdef AD7606_EMU_OSC_EN
    logic [2:0] w_osc_eff;
    assign w_osc_eff   = (i_ad_osc == 3'd7) ? 3'd0 : i_ad_osc;
    assign w_busy_load = BUSY_W'(P_CONV_CYCLES) << w_osc_eff;
`else
    assign w_busy_load = BUSY_W'(P_CONV_CYCLES);
`endif

    assign w_trig    = (i_ad_convstA & i_ad_convstB) & ~conv_and_q;
    assign w_rd_fall = rd_q & ~i_ad_rd & ~i_ad_cs;
    assign w_rd_rise = ~rd_q & i_ad_rd & ~i_ad_cs;
    // Fires on the P_RESET_MIN-th consecutive high cycle of the reset strobe
    assign w_rst_hit = i_ad_reset && (rst_cnt_q >= (c_rst_min - 1'b1));

    ad7606_emu_pattern #(
        .P_CHANNELS (P_CHANNELS)
    ) u_pattern (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_load),
        .o_samples  (w_samples)
    );

    // State, counters, strobe history and registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= DEV_RESET;
            busy_cnt_q <= '0;
            rst_cnt_q  <= '0;
            rd_ptr_q   <= '0;
            reads_q    <= '0;
            rd_q       <= 1'b1;
            conv_and_q <= 1'b0;
            busy_q     <= 1'b0;
            first_q    <= 1'b0;
            data_q     <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_cnt_q <= busy_cnt_d;
            rst_cnt_q  <= rst_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            reads_q    <= reads_d;
            rd_q       <= i_ad_rd;
            conv_and_q <= i_ad_convstA & i_ad_convstB;
            busy_q     <= busy_d;
            first_q    <= first_d;
            data_q     <= data_d;
            overrun_q  <= overrun_d;
        end
    end

    // Next-state: reset qualification, read port, conversion sequencing
    always_comb begin
        state_d    = state_q;
        busy_cnt_d = busy_cnt_q;
        rd_ptr_d   = rd_ptr_q;
        reads_d    = reads_q;
        busy_d     = busy_q;
        first_d    = first_q;
        data_d     = data_q;
        overrun_d  = 1'b0;
        w_load     = 1'b0;

        if (!i_ad_reset) begin
            rst_cnt_d = '0;
        end else if (rst_cnt_q < c_rst_min) begin
            rst_cnt_d = rst_cnt_q + 1'b1;
        end else begin
            rst_cnt_d = rst_cnt_q;
        end

        if (w_rst_hit || state_q == DEV_RESET) begin
            // Outputs parked at their reset values; leave only once a
            // qualified reset pulse has ended.
            state_d    = DEV_RESET;
            busy_cnt_d = '0;
            rd_ptr_d   = '0;
            reads_d    = '0;
            busy_d     = 1'b0;
            first_d    = 1'b0;
            data_d     = '0;
            if (state_q == DEV_RESET && !i_ad_reset && rst_cnt_q >= c_rst_min) begin
                state_d = IDLE;
            end
        end else begin
            if (i_ad_cs) begin
                data_d  = '0;
                first_d = 1'b0;
            end else if (w_rd_fall) begin
                data_d  = w_samples[rd_ptr_q];
                first_d = (rd_ptr_q == '0);
            end else if (w_rd_rise) begin
                first_d  = 1'b0;
                rd_ptr_d = (rd_ptr_q == c_last_chn) ? '0 : rd_ptr_q + 1'b1;
                reads_d  = (reads_q < c_all_reads) ? reads_q + 1'b1 : reads_q;
            end

            case (state_q)
                IDLE, READY: begin
                    // Trigger assignments come last so they override a
                    // coincident rd rising edge.
                    if (w_trig) begin
                        w_load     = 1'b1;
                        rd_ptr_d   = '0;
                        reads_d    = '0;
                        busy_d     = 1'b1;
                        busy_cnt_d = w_busy_load;
                        state_d    = CONVERT;
                        overrun_d  = (state_q == READY) &&
                                     ((rd_ptr_q != '0) || (reads_q < c_all_reads));
                    end
                end
                CONVERT: begin
                    if (busy_cnt_q <= BUSY_W'(1)) begin
                        busy_d  = 1'b0;
                        state_d = READY;
                    end else begin
                        busy_cnt_d = busy_cnt_q - 1'b1;
                    end
                end
                default: state_d = DEV_RESET;
            endcase
        end
    end

    assign o_ad_busy      = busy_q;
    assign o_ad_firstdata = first_q;
    assign o_ad_data      = data_q;
    assign o_overrun      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_ad7606_emulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ad7606_emulator
//  Purpose  : Directed self-checking bench for ad7606_emulator.
//  Options  : AD7606_EMU_OSC_EN selects the oversampled busy expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ad7606_emulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        ad_range;
    logic [2:0]  ad_osc;
    logic        ad_reset;
    logic        ad_convstA;
    logic        ad_convstB;
    logic        ad_cs;
    logic        ad_rd;
    logic        ad_busy;
    logic        ad_firstdata;
    logic [15:0] ad_data;
    logic        overrun;

    int n_tests  = 0;
    int n_fail   = 0;
    int busy_len = 0;

`ifdef AD7606_EMU_OSC_EN
    localparam int EXP_OSC3_LEN = 1600;
`else
    localparam int EXP_OSC3_LEN = 200;
`endif

    always #5 clk = ~clk;

    ad7606_emulator dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_ad_range     (ad_range),
        .i_ad_osc       (ad_osc),
        .i_ad_reset     (ad_reset),
        .i_ad_convstA   (ad_convstA),
        .i_ad_convstB   (ad_convstB),
        .i_ad_cs        (ad_cs),
        .i_ad_rd        (ad_rd),
        .o_ad_busy      (ad_busy),
        .o_ad_firstdata (ad_firstdata),
        .o_ad_data      (ad_data),
        .o_overrun      (overrun)
    );

    // Expected ramp word: channel in the top 3 bits, conversion count below
    function automatic logic [15:0] smp(input int ch, input int cnt);
        logic [15:0] w;
        w = {ch[2:0], cnt[12:0]};
        return w;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset(input int len);
        ad_reset = 1'b1;
        tick(len);
        ad_reset = 1'b0;
        tick(1);
    endtask

    task automatic convst();
        ad_convstA = 1'b1;
        ad_convstB = 1'b1;
        tick(1);
        ad_convstA = 1'b0;
        ad_convstB = 1'b0;
        busy_len   = ad_busy ? 1 : 0;
    endtask

    task automatic wait_busy_low();
        int guard;
        guard = 0;
        tick(1);
        while (ad_busy && guard < 5000) begin
            busy_len++;
            guard++;
            tick(1);
        end
        check("busy_falls", {31'd0, ad_busy}, 32'd0);
    endtask

    task automatic read_ch(input string tag, input logic [15:0] ed, input logic ef);
        ad_rd = 1'b0;
        tick(1);
        check({tag, "_data"}, {16'd0, ad_data}, {16'd0, ed});
        check({tag, "_first"}, {31'd0, ad_firstdata}, {31'd0, ef});
        ad_rd = 1'b1;
        tick(2);
    endtask

    initial begin
        rst        = 1'b1;
        ad_range   = 1'b0;
        ad_osc     = 3'd0;
        ad_reset   = 1'b0;
        ad_convstA = 1'b0;
        ad_convstB = 1'b0;
        ad_cs      = 1'b1;
        ad_rd      = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);

        check("rst_busy",  {31'd0, ad_busy}, 32'd0);
        check("rst_first", {31'd0, ad_firstdata}, 32'd0);
        check("rst_data",  {16'd0, ad_data}, 32'd0);
        check("rst_ovr",   {31'd0, overrun}, 32'd0);

        // Too-short device reset keeps the part in DEV_RESET
        pulse_reset(2);
        convst();
        check("short_rst_busy", {31'd0, ad_busy}, 32'd0);
        ad_cs = 1'b0;
        tick(1);
        read_ch("devrst_rd", 16'h0000, 1'b0);
        ad_cs = 1'b1;
        tick(1);

        // Qualified reset, then first conversion (count 0)
        pulse_reset(3);
        convst();
        check("start_busy", {31'd0, ad_busy}, 32'd1);
        wait_busy_low();
        check("busy_len_nom", busy_len, 200);
        ad_cs = 1'b0;
        tick(1);
        for (int n = 0; n < 8; n++) read_ch($sformatf("c0_ch%0d", n), smp(n, 0), n == 0);

        // Second conversion after a full read (count 1)
        convst();
        check("no_ovr_full", {31'd0, overrun}, 32'd0);
        wait_busy_low();
        check("busy_len_2", busy_len, 200);
        for (int n = 0; n < 8; n++) read_ch($sformatf("c1_ch%0d", n), smp(n, 1), n == 0);

        // Partial read followed by a new conversion raises overrun
        convst();
        wait_busy_low();
        for (int n = 0; n < 3; n++) read_ch($sformatf("c2_ch%0d", n), smp(n, 2), n == 0);
        convst();
        check("overrun_pulse", {31'd0, overrun}, 32'd1);
        tick(1);
        check("overrun_1cyc", {31'd0, overrun}, 32'd0);
        read_ch("conv_rd", smp(0, 3), 1'b1);
        wait_busy_low();

        // Second convst edge 50 cycles into a conversion is ignored (count 4)
        convst();
        repeat (49) begin
            tick(1);
            if (ad_busy) busy_len++;
        end
        ad_convstA = 1'b1;
        ad_convstB = 1'b1;
        tick(1);
        if (ad_busy) busy_len++;
        ad_convstA = 1'b0;
        ad_convstB = 1'b0;
        wait_busy_low();
        check("busy_len_ign", busy_len, 200);
        read_ch("ign_ch0", smp(0, 4), 1'b1);

        // Next conversion is count 5; one channel read leaves an overrun
        convst();
        check("overrun_part", {31'd0, overrun}, 32'd1);
        wait_busy_low();
        for (int n = 0; n < 9; n++) read_ch($sformatf("wrap_rd%0d", n), smp(n % 8, 5), (n % 8) == 0);

        // rd pulses with cs high return 0 and leave the pointer at 1
        ad_cs = 1'b1;
        tick(1);
        check("csh_data",  {16'd0, ad_data}, 32'd0);
        check("csh_first", {31'd0, ad_firstdata}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            ad_rd = 1'b0;
            tick(1);
            check($sformatf("csh_rd%0d", i), {16'd0, ad_data}, 32'd0);
            ad_rd = 1'b1;
            tick(1);
        end
        ad_cs = 1'b0;
        tick(1);
        read_ch("after_csh", smp(1, 5), 1'b0);

        // rd rising edge coincident with a trigger: pointer restarts at 0
        ad_rd = 1'b0;
        tick(1);
        check("pre_sim_data", {16'd0, ad_data}, {16'd0, smp(2, 5)});
        ad_rd = 1'b1;
        convst();
        wait_busy_low();
        read_ch("sim_ch0", smp(0, 6), 1'b1);

        // Oversampling select
        ad_osc = 3'd3;
        convst();
        wait_busy_low();
        check("busy_len_osc3", busy_len, EXP_OSC3_LEN);
        ad_osc = 3'd7;
        convst();
        wait_busy_low();
        check("busy_len_osc7", busy_len, 200);
        ad_osc = 3'd0;

        // Device reset mid-conversion: short pulse ignored, full one aborts
        convst();
        tick(20);
        pulse_reset(2);
        check("short_rst_ign", {31'd0, ad_busy}, 32'd1);
        pulse_reset(3);
        check("abort_busy", {31'd0, ad_busy}, 32'd0);
        check("abort_data", {16'd0, ad_data}, 32'd0);
        convst();
        check("idle_restart", {31'd0, ad_busy}, 32'd1);
        check("idle_no_ovr", {31'd0, overrun}, 32'd0);
        wait_busy_low();
        check("busy_len_post", busy_len, 200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
